// File: rtl/rr_mux_arbiter_pkg.sv
// rr_mux_arbiter_pkg: shared word-bus widths, requester count
// and FSM encodings for the round-robin word-mux arbiter.
package rr_mux_arbiter_pkg;

   localparam int WORD_W  = 32;
   localparam int NUM_REQ = 4;
   localparam int SEL_W   = 2;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2,
      ARB_ACK   = 2'd3
   } arb_state_e;

   function automatic logic [NUM_REQ-1:0] sel2oh(
      input logic [SEL_W-1:0] s
   );
      return NUM_REQ'(1) << s;
   endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// rr_mux_arbiter_if: requester/resource handshake bundle.
// timeout_err exists only when ARB_TIMEOUT_EN is defined.
interface rr_mux_arbiter_if;
   import rr_mux_arbiter_pkg::*;

   logic [NUM_REQ-1:0] req;
   logic               done;
   logic [SEL_W-1:0]   sel;
   logic               issue;
   logic               busy;
   logic [NUM_REQ-1:0] ack;
`ifdef ARB_TIMEOUT_EN
   logic               timeout_err;

   modport master (
      input  req, done,
      output sel, issue, busy, ack, timeout_err
   );
   modport slave (
      output req, done,
      input  sel, issue, busy, ack, timeout_err
   );
`else
   modport master (
      input  req, done,
      output sel, issue, busy, ack
   );
   modport slave (
      output req, done,
      input  sel, issue, busy, ack
   );
`endif

endinterface

// File: rtl/rr_mux_arbiter_rr_pick.sv
// rr_pick: rotate-priority encoder, first set req bit at or
// after ptr, scanning upward modulo NUM_REQ.
module rr_pick
   import rr_mux_arbiter_pkg::*;
(
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [SEL_W-1:0]   ptr_i,
   output logic [SEL_W-1:0]   grant_idx_o,
   output logic               any_o
);

   logic [SEL_W-1:0] idx;

   // Scan farthest-first so the nearest hit overwrites last.
   always_comb begin
      grant_idx_o = ptr_i;
      any_o       = 1'b0;
      idx         = ptr_i;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = ptr_i + SEL_W'(i);
         if (req_i[idx]) begin
            grant_idx_o = idx;
            any_o       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin owner of the shared word mux.
// Define ARB_TIMEOUT_EN to abort hung transactions.
module rr_mux_arbiter #(
   parameter int NUM_REQ = 4
`ifdef ARB_TIMEOUT_EN
   ,
   parameter int TIMEOUT = 16
`endif
) (
   input logic           clk,
   input logic           rst_n,
   rr_mux_arbiter_if.master bus
);
   import rr_mux_arbiter_pkg::*;

   arb_state_e         state_q, state_d;
   logic [SEL_W-1:0]   ptr_q, ptr_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [NUM_REQ-1:0] ack_q, ack_d;
   logic               issue_q, busy_q;
   logic [SEL_W-1:0]   grant_idx;
   logic               any;

   rr_pick u_pick (
      .req_i       (bus.req),
      .ptr_i       (ptr_q),
      .grant_idx_o (grant_idx),
      .any_o       (any)
   );

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             to_q, to_d;
   logic             expire;

   assign expire = (cnt_q == CNT_W'(TIMEOUT - 1));
`endif

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      ack_d   = '0;
`ifdef ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
      to_d    = 1'b0;
`endif
      unique case (state_q)
         ARB_IDLE: begin
            if (any) begin
               sel_d   = grant_idx;
               state_d = ARB_ISSUE;
`ifdef ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         ARB_ISSUE, ARB_WAIT: begin
            if (bus.done) begin
               state_d = ARB_ACK;
               ack_d   = sel2oh(sel_q);
`ifdef ARB_TIMEOUT_EN
            end else if (expire) begin
               state_d = ARB_ACK;
               to_d    = 1'b1;
            end else begin
               state_d = ARB_WAIT;
               cnt_d   = cnt_q + 1'b1;
`else
            end else begin
               state_d = ARB_WAIT;
`endif
            end
         end
         ARB_ACK: begin
            ptr_d   = sel_q + 1'b1;
            state_d = ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ARB_IDLE;
         ptr_q   <= '0;
         sel_q   <= '0;
         ack_q   <= '0;
         issue_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         ack_q   <= ack_d;
         issue_q <= (state_d == ARB_ISSUE);
         busy_q  <= (state_d != ARB_IDLE);
      end
   end

`ifdef ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         to_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         to_q  <= to_d;
      end
   end

   assign bus.timeout_err = to_q;
`endif

   assign bus.sel   = sel_q;
   assign bus.issue = issue_q;
   assign bus.busy  = busy_q;
   assign bus.ack   = ack_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed checks of grant order, handshake
// timing and reset for rr_mux_arbiter.
module tb_rr_mux_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;

   rr_mux_arbiter_if bus ();

   rr_mux_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n    = 1'b0;
      bus.req  = '0;
      bus.done = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if (bus.sel !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_sel got %0d want 0", bus.sel);
      end
      n_tests++;
      if (bus.issue !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_issue got %0b want 0", bus.issue);
      end
      n_tests++;
      if (bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_busy got %0b want 0", bus.busy);
      end
      n_tests++;
      if (bus.ack !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_ack got %b want 0000", bus.ack);
      end
`ifdef ARB_TIMEOUT_EN
      n_tests++;
      if (bus.timeout_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_terr got %0b want 0", bus.timeout_err);
      end
`endif
      rst_n = 1'b1;
      step();
      n_tests++;
      if (bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_noreq_busy got %0b want 0", bus.busy);
      end
   endtask

   // req=1111 held, done one cycle after each issue
   task automatic test_fairness;
      logic [1:0] exp_g [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      logic [1:0] g[$];
      int         icyc[$];
      int         acyc[$];
      logic [3:0] aval[$];
      logic       last_iss = 1'b0;
      bus.req = 4'b1111;
      for (int c = 1; c <= 30; c++) begin
         step();
         if (bus.issue) begin
            g.push_back(bus.sel);
            icyc.push_back(c);
            if (g.size() == 5) bus.req = '0;
         end
         if (bus.ack !== 4'b0000) begin
            aval.push_back(bus.ack);
            acyc.push_back(c);
         end
         bus.done = last_iss;
         last_iss = bus.issue;
      end
      bus.done = 1'b0;
      n_tests++;
      if (g.size() != 5 || aval.size() != 5) begin
         n_fail++;
         $display("FAIL fair_count grants %0d acks %0d want 5 5",
                  g.size(), aval.size());
      end
      for (int i = 0; i < 5; i++) begin
         if (i < g.size()) begin
            n_tests++;
            if (g[i] !== exp_g[i]) begin
               n_fail++;
               $display("FAIL fair_grant%0d got %0d want %0d",
                        i, g[i], exp_g[i]);
            end
         end
         if (i < aval.size() && i < icyc.size()) begin
            n_tests++;
            if (aval[i] !== (4'b0001 << exp_g[i]) ||
                acyc[i] != icyc[i] + 2) begin
               n_fail++;
               $display("FAIL fair_ack%0d got %b@%0d want %b@%0d",
                        i, aval[i], acyc[i],
                        4'b0001 << exp_g[i], icyc[i] + 2);
            end
         end
         if (i > 0 && i < icyc.size()) begin
            n_tests++;
            if (icyc[i] - icyc[i-1] != 4) begin
               n_fail++;
               $display("FAIL fair_gap%0d got %0d want 4",
                        i, icyc[i] - icyc[i-1]);
            end
         end
      end
   endtask

   // req=0100, done two cycles after issue
   task automatic test_single;
      int         n_iss = 0;
      int         n_busy = 0;
      int         n_ack = 0;
      int         ack_cyc = -1;
      logic [1:0] sel_iss = 2'd0;
      logic [3:0] ack_seen = 4'b0000;
      bus.req = 4'b0100;
      for (int c = 1; c <= 8; c++) begin
         step();
         bus.req = '0;
         if (bus.issue) begin
            n_iss++;
            sel_iss = bus.sel;
         end
         if (bus.busy) n_busy++;
         if (bus.ack !== 4'b0000) begin
            n_ack++;
            ack_seen = bus.ack;
            ack_cyc  = c;
         end
         bus.done = (c == 3);
      end
      n_tests++;
      if (n_iss != 1 || sel_iss !== 2'd2) begin
         n_fail++;
         $display("FAIL single_issue got %0d pulses sel %0d want 1 sel 2",
                  n_iss, sel_iss);
      end
      n_tests++;
      if (n_busy != 4) begin
         n_fail++;
         $display("FAIL single_busy got %0d cycles want 4", n_busy);
      end
      n_tests++;
      if (n_ack != 1 || ack_seen !== 4'b0100 || ack_cyc != 4) begin
         n_fail++;
         $display("FAIL single_ack got %0d x %b@%0d want 1 x 0100@4",
                  n_ack, ack_seen, ack_cyc);
      end
   endtask

   // ptr=3, req=0011, done in the issue cycle
   task automatic test_wrap;
      logic [1:0] g[$];
      int         icyc[$];
      int         acyc[$];
      int         n_busy = 0;
      bus.req = 4'b0011;
      for (int c = 1; c <= 12; c++) begin
         step();
         if (bus.issue) begin
            g.push_back(bus.sel);
            icyc.push_back(c);
            if (g.size() == 2) bus.req = '0;
         end
         if (bus.busy) n_busy++;
         if (bus.ack !== 4'b0000) acyc.push_back(c);
         bus.done = bus.issue;
      end
      bus.done = 1'b0;
      n_tests++;
      if (g.size() != 2) begin
         n_fail++;
         $display("FAIL wrap_count got %0d want 2", g.size());
      end else begin
         n_tests++;
         if (g[0] !== 2'd0 || g[1] !== 2'd1) begin
            n_fail++;
            $display("FAIL wrap_order got %0d,%0d want 0,1", g[0], g[1]);
         end
         n_tests++;
         if (icyc[1] - icyc[0] != 3) begin
            n_fail++;
            $display("FAIL b2b_gap got %0d want 3", icyc[1] - icyc[0]);
         end
      end
      n_tests++;
      if (acyc.size() != 2 || icyc.size() != 2) begin
         n_fail++;
         $display("FAIL imm_ack_count got %0d want 2", acyc.size());
      end else if (acyc[0] != icyc[0] + 1 || acyc[1] != icyc[1] + 1) begin
         n_fail++;
         $display("FAIL imm_ack_cyc got %0d,%0d want %0d,%0d",
                  acyc[0], acyc[1], icyc[0] + 1, icyc[1] + 1);
      end
      n_tests++;
      if (n_busy != 4) begin
         n_fail++;
         $display("FAIL imm_busy got %0d want 4", n_busy);
      end
   endtask

   // req=0010 dropped in the issue cycle, done three cycles later
   task automatic test_dropped_req;
      int         n_ack = 0;
      int         ack_cyc = -1;
      int         n_busy = 0;
      logic [1:0] sel_iss = 2'd3;
      logic [3:0] ack_seen = 4'b0000;
      bus.req = 4'b0010;
      for (int c = 1; c <= 8; c++) begin
         step();
         bus.req = '0;
         if (bus.issue) sel_iss = bus.sel;
         if (bus.busy) n_busy++;
         if (bus.ack !== 4'b0000) begin
            n_ack++;
            ack_seen = bus.ack;
            ack_cyc  = c;
         end
         bus.done = (c == 4);
      end
      n_tests++;
      if (sel_iss !== 2'd1) begin
         n_fail++;
         $display("FAIL drop_sel got %0d want 1", sel_iss);
      end
      n_tests++;
      if (n_ack != 1 || ack_seen !== 4'b0010 || ack_cyc != 5) begin
         n_fail++;
         $display("FAIL drop_ack got %0d x %b@%0d want 1 x 0010@5",
                  n_ack, ack_seen, ack_cyc);
      end
      n_tests++;
      if (n_busy != 5) begin
         n_fail++;
         $display("FAIL drop_busy got %0d want 5", n_busy);
      end
   endtask

   // reset during WAIT of a grant to 3, then re-request 0101
   task automatic test_reset_midwait;
      int         n_ack = 0;
      int         iss_cyc = -1;
      int         ack_cyc = -1;
      logic [1:0] sel_iss = 2'd3;
      logic [3:0] ack_seen = 4'b0000;
      bus.req = 4'b1000;
      step();
      bus.req = '0;
      step();
      step();
      n_tests++;
      if (bus.busy !== 1'b1 || bus.sel !== 2'd3) begin
         n_fail++;
         $display("FAIL pre_rst got busy %0b sel %0d want 1 3",
                  bus.busy, bus.sel);
      end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (bus.busy !== 1'b0 || bus.sel !== 2'd0 ||
          bus.ack !== 4'b0000 || bus.issue !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid got busy %0b sel %0d ack %b want 0 0 0000",
                  bus.busy, bus.sel, bus.ack);
      end
      repeat (2) @(negedge clk);
      rst_n   = 1'b1;
      bus.req = 4'b0101;
      for (int c = 1; c <= 8; c++) begin
         step();
         if (bus.issue) begin
            sel_iss = bus.sel;
            iss_cyc = c;
            bus.req = '0;
         end
         if (bus.ack !== 4'b0000) begin
            n_ack++;
            ack_seen = bus.ack;
            ack_cyc  = c;
         end
         bus.done = bus.issue;
      end
      bus.done = 1'b0;
      n_tests++;
      if (sel_iss !== 2'd0 || iss_cyc != 1) begin
         n_fail++;
         $display("FAIL rst_regrant got sel %0d@%0d want 0@1",
                  sel_iss, iss_cyc);
      end
      n_tests++;
      if (n_ack != 1 || ack_seen !== 4'b0001 || ack_cyc != 2) begin
         n_fail++;
         $display("FAIL rst_ack got %0d x %b@%0d want 1 x 0001@2",
                  n_ack, ack_seen, ack_cyc);
      end
   endtask

`ifdef ARB_TIMEOUT_EN
   // req=0110 from ptr 1, done withheld on the first grant
   task automatic test_timeout;
      logic [1:0] g[$];
      int         icyc[$];
      int         tcyc[$];
      int         acyc[$];
      logic [3:0] aval[$];
      bus.req  = 4'b0110;
      bus.done = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         step();
         if (bus.issue) begin
            g.push_back(bus.sel);
            icyc.push_back(c);
            if (g.size() == 2) bus.req = '0;
         end
         if (bus.timeout_err) tcyc.push_back(c);
         if (bus.ack !== 4'b0000) begin
            aval.push_back(bus.ack);
            acyc.push_back(c);
         end
         bus.done = bus.issue && (g.size() == 2);
      end
      bus.done = 1'b0;
      n_tests++;
      if (g.size() != 2) begin
         n_fail++;
         $display("FAIL to_grants got %0d want 2", g.size());
      end else begin
         n_tests++;
         if (g[0] !== 2'd1 || g[1] !== 2'd2) begin
            n_fail++;
            $display("FAIL to_order got %0d,%0d want 1,2", g[0], g[1]);
         end
      end
      n_tests++;
      if (tcyc.size() != 1 || icyc.size() < 1) begin
         n_fail++;
         $display("FAIL to_err_count got %0d want 1", tcyc.size());
      end else if (tcyc[0] != icyc[0] + 16) begin
         n_fail++;
         $display("FAIL to_err_cyc got %0d want %0d",
                  tcyc[0], icyc[0] + 16);
      end
      n_tests++;
      if (aval.size() != 1 || icyc.size() != 2) begin
         n_fail++;
         $display("FAIL to_ack_count got %0d want 1", aval.size());
      end else if (aval[0] !== 4'b0100 || acyc[0] != icyc[1] + 1) begin
         n_fail++;
         $display("FAIL to_ack got %b@%0d want 0100@%0d",
                  aval[0], acyc[0], icyc[1] + 1);
      end
   endtask
`endif

   initial begin
      bus.req  = '0;
      bus.done = 1'b0;
      test_reset();
      test_fairness();
      test_single();
      test_wrap();
      test_dropped_req();
      test_reset_midwait();
`ifdef ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
